// File: rtl/and_gate_unit.sv
// Bitwise AND primitive: combinational a & b, plus a registered, valid-qualified copy,
// reduction flags on the registered result and a saturating all-ones match counter.
module and_gate_unit #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             all_ones,
  output logic             any_one,
  output logic [CNT_W-1:0] match_cnt
);

  logic [WIDTH-1:0] w_and;
  logic             w_match;
  logic             w_cnt_sat;

  logic [WIDTH-1:0] r_y_q;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_match_cnt;

  assign w_and     = a & b;
  assign w_match   = &w_and;
  assign w_cnt_sat = &r_match_cnt;

  // Clear outranks in_valid; the counter stops at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q       <= '0;
      r_out_valid <= 1'b0;
      r_match_cnt <= '0;
    end else if (clear) begin
      r_y_q       <= '0;
      r_out_valid <= 1'b0;
      r_match_cnt <= '0;
    end else if (in_valid) begin
      r_y_q       <= w_and;
      r_out_valid <= 1'b1;
      if (w_match && !w_cnt_sat) begin
        r_match_cnt <= r_match_cnt + CNT_W'(1);
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign y         = w_and;
  assign y_q       = r_y_q;
  assign out_valid = r_out_valid;
  assign all_ones  = &r_y_q;
  assign any_one   = |r_y_q;
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_and_gate_unit.sv
// Scoreboarded bench for and_gate_unit: a 4-bit/2-bit-counter instance driven with directed
// and random traffic, plus an idle-clock 1-bit instance for the combinational truth table.
module tb_and_gate_unit;

  localparam int unsigned W      = 4;
  localparam int unsigned CW     = 2;
  localparam int unsigned MaxCnt = (1 << CW) - 1;
  localparam logic [W-1:0] Ones  = '1;

  typedef struct {
    logic [W-1:0]  yq;
    int unsigned   cnt;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [W-1:0]  a, b;
  logic          in_valid, clear;
  logic [W-1:0]  y, y_q;
  logic          out_valid, all_ones, any_one;
  logic [CW-1:0] match_cnt;

  logic          clk_idle;
  logic          a1, b1;
  logic          y1, y_q1, out_valid1, all_ones1, any_one1;
  logic [15:0]   match_cnt1;

  int unsigned   total;
  int unsigned   bad;
  exp_t          sb[$];
  logic [W-1:0]  m_yq;
  int unsigned   m_cnt;

  and_gate_unit #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .clear     (clear),
    .y         (y),
    .y_q       (y_q),
    .out_valid (out_valid),
    .all_ones  (all_ones),
    .any_one   (any_one),
    .match_cnt (match_cnt)
  );

  and_gate_unit #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk       (clk_idle),
    .rst       (rst),
    .a         (a1),
    .b         (b1),
    .in_valid  (1'b0),
    .clear     (1'b0),
    .y         (y1),
    .y_q       (y_q1),
    .out_valid (out_valid1),
    .all_ones  (all_ones1),
    .any_one   (any_one1),
    .match_cnt (match_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  // Drive one cycle of inputs; after the edge, advance the reference model and log the result.
  task automatic step(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tv,
                      input logic tc);
    exp_t e;
    a = ta; b = tb; in_valid = tv; clear = tc;
    @(posedge clk);
    if (tc) begin
      m_yq  = '0;
      m_cnt = 0;
    end else if (tv) begin
      m_yq = ta & tb;
      if (m_yq == Ones) m_cnt = (m_cnt + 1 > MaxCnt) ? MaxCnt : m_cnt + 1;
      e.yq  = m_yq;
      e.cnt = m_cnt;
      sb.push_back(e);
    end
    #1;
  endtask

  // Monitor: every cycle the DUT claims a result, it must match the oldest logged expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("y_comb", 32'(y), 32'(a & b));
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (out_valid && sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_y_q", 32'(y_q), 32'(e.yq));
        check("sb_match_cnt", 32'(match_cnt), e.cnt);
        check("sb_all_ones", 32'(all_ones), 32'(e.yq == Ones));
        check("sb_any_one", 32'(any_one), 32'(e.yq != '0));
      end else begin
        sb.delete();
        check("hold_y_q", 32'(y_q), 32'(m_yq));
        check("hold_match_cnt", 32'(match_cnt), m_cnt);
      end
    end
  end

  initial begin
    logic [1:0] tt;
    logic [W-1:0] ra, rb;
    total = 0; bad = 0; m_yq = '0; m_cnt = 0;
    clk_idle = 1'b0; a1 = 1'b0; b1 = 1'b0;
    a = '0; b = '0; in_valid = 1'b0; clear = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_y_q", 32'(y_q), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_match_cnt", 32'(match_cnt), 0);
    check("rst_all_ones", 32'(all_ones), 0);
    check("rst_any_one", 32'(any_one), 0);
    check("rst_all_ones_w1", 32'(all_ones1), 0);

    // Truth table on the idle-clock 1-bit instance.
    for (int i = 0; i < 4; i++) begin
      tt = 2'(i);
      a1 = tt[1]; b1 = tt[0];
      #10;
      check("truth_table_y", 32'(y1), 32'(i == 3));
    end

    @(posedge clk);
    #1 rst = 1'b0;

    step(4'b1100, 4'b1010, 1'b1, 1'b0);
    check("reg_y_q", 32'(y_q), 32'h8);
    check("reg_out_valid", 32'(out_valid), 1);
    check("reg_any_one", 32'(any_one), 1);
    check("reg_all_ones", 32'(all_ones), 0);
    check("reg_match_cnt", 32'(match_cnt), 0);

    for (int i = 0; i < 3; i++) step(Ones, Ones, 1'b1, 1'b0);
    step('0, Ones, 1'b1, 1'b0);
    check("match_cnt_3", 32'(match_cnt), 3);
    step('0, '0, 1'b0, 1'b0);
    check("valid_drop", 32'(out_valid), 0);

    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(Ones, Ones, 1'b1, 1'b0);
      check("saturation", 32'(match_cnt), (i < 3) ? i + 1 : 3);
    end

    step(Ones, Ones, 1'b1, 1'b1);
    check("clear_pri_y_q", 32'(y_q), 0);
    check("clear_pri_out_valid", 32'(out_valid), 0);
    check("clear_pri_match_cnt", 32'(match_cnt), 0);

    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? Ones : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? Ones : W'($urandom);
      step(ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset between edges with the counter at 2.
    step('0, '0, 1'b0, 1'b1);
    step(Ones, Ones, 1'b1, 1'b0);
    step(Ones, Ones, 1'b1, 1'b0);
    check("pre_rst_cnt", 32'(match_cnt), 2);
    a = 4'b0110; b = 4'b0011;
    #2 rst = 1'b1;
    m_yq = '0; m_cnt = 0; sb.delete();
    #1;
    check("arst_y_q", 32'(y_q), 0);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_match_cnt", 32'(match_cnt), 0);
    check("arst_any_one", 32'(any_one), 0);
    check("arst_y", 32'(y), 32'h2);
    in_valid = 1'b1; a = Ones; b = Ones;
    @(posedge clk);
    #1;
    check("rst_hold_out_valid", 32'(out_valid), 0);
    check("rst_hold_cnt", 32'(match_cnt), 0);
    in_valid = 1'b0;
    rst = 1'b0;
    step(Ones, Ones, 1'b1, 1'b0);
    check("post_rst_capture", 32'(match_cnt), 1);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/and_gate_unit.md
# and_gate_unit

Bitwise two-input AND block with a zero-latency combinational output and a registered, valid-qualified copy, plus reduction flags and a saturating match counter. It is the basic logic primitive of the CI demo datapath: downstream logic reads `y` directly for combinational use, or `y_q`/`out_valid` for pipelined use. With `WIDTH = 1` the combinational path `y` is a plain 2-input AND gate.

## Interface
- `WIDTH`, default 1: operand width in bits (≥ 1).
- `CNT_W`, default 16: width of the match counter (≥ 1).

- `clk`  input  1  sole clock, rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `in_valid`  input  1  qualifies `a`/`b` for the registered path.
- `clear`  input  1  synchronous clear of registered state and counter.
- `y`  output  WIDTH  combinational `a & b`, no clock dependency.
- `y_q`  output  WIDTH  registered `a & b`, captured when `in_valid`.
- `out_valid`  output  1  `y_q` holds a result captured on the previous edge.
- `all_ones`  output  1  `&y_q` (every bit of the registered result set).
- `any_one`  output  1  `|y_q`.
- `match_cnt`  output  CNT_W  saturating count of accepted inputs whose result had `all_ones`.

## Operation
- `y = a & b` bitwise, purely combinational, independent of `clk`, `rst`, `in_valid`, `clear`. For `WIDTH = 1`: 00→0, 01→0, 10→0, 11→1.
- X/Z on an input bit propagates per standard Verilog `&` semantics; no masking.
- On each rising `clk` edge, in priority order:
  - `clear = 1`: `y_q ← 0`, `out_valid ← 0`, `match_cnt ← 0`. Takes precedence over `in_valid`.
  - else `in_valid = 1`: `y_q ← a & b`, `out_valid ← 1`; if `&(a & b)` then `match_cnt ← match_cnt + 1`, saturating at `2^CNT_W − 1` (no wrap).
  - else: `y_q` holds, `out_valid ← 0`, `match_cnt` holds.
- `all_ones` and `any_one` are combinational decodes of `y_q` (not of `y`).
- No back-pressure: every `in_valid` cycle is accepted.

## Timing
- `y`: zero-cycle latency; settles within one propagation delay of `a`/`b` changes. Must be valid 10 ns after an input change with no clock running.
- `y_q`, `out_valid`, `match_cnt`: one-cycle latency from the `in_valid` edge.
- `out_valid` is a one-cycle pulse per accepted input; back-to-back `in_valid` keeps it high continuously.
- Reset (`rst = 1`, asynchronous, immediate, no clock needed): `y_q = 0`, `out_valid = 0`, `match_cnt = 0`, hence `all_ones = 0` (for any WIDTH) and `any_one = 0`. `y` is unaffected by reset and continues to track `a & b`.
- Reset asserted mid-stream discards any result in flight. First capture after deassertion occurs on the first rising edge with `rst = 0` and `in_valid = 1`.
- Counter at saturation with further matches: stays at `2^CNT_W − 1`.

## Test plan
- Truth table, `WIDTH = 1`, clock idle: apply (a,b) = (0,0), (0,1), (1,0), (1,1), wait 10 ns each → `y` = 0, 0, 0, 1.
- Registered path, `WIDTH = 4`: `in_valid = 1`, a = 4'b1100, b = 4'b1010 → next edge: `y_q = 4'b1000`, `out_valid = 1`, `any_one = 1`, `all_ones = 0`, `match_cnt` unchanged.
- Match counting: three valid cycles with a = b = all-ones, then one with a = 0 → `match_cnt = 3`; `out_valid` high for 4 cycles, then low when `in_valid` drops.
- Saturation, `CNT_W = 2`: five consecutive all-ones matches → `match_cnt` = 1, 2, 3, 3, 3.
- Clear priority: `clear = 1` and `in_valid = 1` on the same edge with a matching input → `y_q = 0`, `out_valid = 0`, `match_cnt = 0`.
- Async reset mid-operation: assert `rst` between edges while `match_cnt = 2` → registered outputs go to 0 immediately, without a clock edge; `y` still equals `a & b` throughout.
